// File: rtl/ddram_bram_responder.sv
// Block-RAM stand-in for the DDR3 controller on the DDRAM Avalon-MM bus (bursts, byte enables, refresh stalls).
// Latency: first read beat READ_LATENCY cycles after acceptance, then one beat per cycle; writes land at the accepting edge.
// Backpressure: DDRAM_BUSY holds off new commands during a read, a refresh, or while a refresh is pending in IDLE.
module ddram_bram_responder #(
  parameter int ADDR_BITS      = 12,
  parameter int READ_LATENCY   = 4,
  parameter int REFRESH_PERIOD = 256,
  parameter int REFRESH_LEN    = 8
) (
  input  logic        clk,
  input  logic        reset,
  output logic        DDRAM_BUSY,
  input  logic [7:0]  DDRAM_BURSTCNT,
  input  logic [28:0] DDRAM_ADDR,
  output logic [63:0] DDRAM_DOUT,
  output logic        DDRAM_DOUT_READY,
  input  logic        DDRAM_RD,
  input  logic [63:0] DDRAM_DIN,
  input  logic [7:0]  DDRAM_BE,
  input  logic        DDRAM_WE,
  output logic        err
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WBURST  = 3'd1;
  localparam logic [2:0] RLAT    = 3'd2;
  localparam logic [2:0] RBURST  = 3'd3;
  localparam logic [2:0] REFRESH = 3'd4;

  localparam int LAT_W = $clog2(READ_LATENCY + 1);
  localparam int RP    = (REFRESH_PERIOD > 1) ? REFRESH_PERIOD : 2;
  localparam int RC_W  = $clog2(RP);
  localparam int RL    = (REFRESH_LEN > 0) ? REFRESH_LEN : 1;
  localparam int RL_W  = $clog2(RL + 1);

  logic [63:0]          mem [2**ADDR_BITS];
  logic [2:0]           state;
  logic [ADDR_BITS-1:0] addr_q;
  logic [7:0]           remaining;
  logic [LAT_W-1:0]     lat_cnt;
  logic [RC_W-1:0]      ref_ctr;
  logic [RL_W-1:0]      ref_len_cnt;
  logic                 refresh_pending;

  logic                 ref_wrap;
  logic                 accept;
  logic                 wr_en;
  logic [7:0]           cmd_cnt;
  logic [ADDR_BITS-1:0] cmd_addr;
  logic [ADDR_BITS-1:0] wr_addr;
  logic                 unused_addr;

  assign unused_addr = ^DDRAM_ADDR[28:ADDR_BITS];
  assign cmd_addr    = DDRAM_ADDR[ADDR_BITS-1:0];
  assign cmd_cnt     = (DDRAM_BURSTCNT == 8'd0) ? 8'd1 : DDRAM_BURSTCNT;

  assign DDRAM_BUSY = (state == RLAT) || (state == RBURST) || (state == REFRESH) ||
                      ((state == IDLE) && refresh_pending);

  assign accept   = (state == IDLE) && !refresh_pending && (DDRAM_RD || DDRAM_WE);
  assign ref_wrap = (REFRESH_PERIOD != 0) && (ref_ctr == RC_W'(REFRESH_PERIOD - 1));
  // A write wins over a simultaneous read; beats presented during reset are dropped.
  assign wr_en    = !reset && DDRAM_WE && (accept || (state == WBURST));
  assign wr_addr  = (state == WBURST) ? addr_q : cmd_addr;

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 8; i++) begin
        if (DDRAM_BE[i]) mem[wr_addr][8*i +: 8] <= DDRAM_DIN[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      addr_q           <= '0;
      remaining        <= 8'd0;
      lat_cnt          <= '0;
      ref_ctr          <= '0;
      ref_len_cnt      <= '0;
      refresh_pending  <= 1'b0;
      DDRAM_DOUT       <= 64'd0;
      DDRAM_DOUT_READY <= 1'b0;
      err              <= 1'b0;
    end else begin
      ref_ctr          <= ref_wrap ? '0 : ref_ctr + 1'b1;
      DDRAM_DOUT_READY <= 1'b0;
      if (ref_wrap)
        refresh_pending <= 1'b1;
      else if ((state == IDLE) && refresh_pending)
        refresh_pending <= 1'b0;

      case (state)
        IDLE: begin
          if (refresh_pending) begin
            state       <= REFRESH;
            ref_len_cnt <= RL_W'(RL - 1);
          end else if (accept) begin
            if ((DDRAM_BURSTCNT == 8'd0) || (DDRAM_RD && DDRAM_WE)) err <= 1'b1;
            if (DDRAM_WE) begin
              addr_q    <= cmd_addr + 1'b1;
              remaining <= cmd_cnt - 8'd1;
              if (cmd_cnt > 8'd1) state <= WBURST;
            end else begin
              addr_q    <= cmd_addr;
              remaining <= cmd_cnt;
              lat_cnt   <= LAT_W'(READ_LATENCY - 1);
              state     <= RLAT;
            end
          end
        end
        WBURST: begin
          if (DDRAM_WE) begin
            addr_q    <= addr_q + 1'b1;
            remaining <= remaining - 8'd1;
            if (remaining == 8'd1) state <= IDLE;
          end
        end
        RLAT: begin
          if (lat_cnt == '0) begin
            DDRAM_DOUT_READY <= 1'b1;
            DDRAM_DOUT       <= mem[addr_q];
            addr_q           <= addr_q + 1'b1;
            remaining        <= remaining - 8'd1;
            state            <= RBURST;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        RBURST: begin
          // Stay busy through the final beat's cycle, release on the next edge.
          if (remaining != 8'd0) begin
            DDRAM_DOUT_READY <= 1'b1;
            DDRAM_DOUT       <= mem[addr_q];
            addr_q           <= addr_q + 1'b1;
            remaining        <= remaining - 8'd1;
          end else begin
            state <= IDLE;
          end
        end
        REFRESH: begin
          if (ref_len_cnt == '0) state <= IDLE;
          else ref_len_cnt <= ref_len_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddram_bram_responder.sv
// Randomised bus master plus a cycle-level reference model of the DDRAM responder,
// with directed scenarios pinned to hand-computed values.
module tb_ddram_bram_responder;

  localparam int AB  = 12;
  localparam int LAT = 4;
  localparam int RP  = 16;
  localparam int RL  = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        DDRAM_BUSY;
  logic [7:0]  DDRAM_BURSTCNT;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DOUT;
  logic        DDRAM_DOUT_READY;
  logic        DDRAM_RD;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;
  logic        DDRAM_WE;
  logic        err;

  always #5 clk = ~clk;

  ddram_bram_responder #(
    .ADDR_BITS(AB), .READ_LATENCY(LAT), .REFRESH_PERIOD(RP), .REFRESH_LEN(RL)
  ) dut (
    .clk(clk), .reset(reset), .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_BURSTCNT(DDRAM_BURSTCNT),
    .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY),
    .DDRAM_RD(DDRAM_RD), .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE), .DDRAM_WE(DDRAM_WE),
    .err(err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  logic chk_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: timeline of busy windows and scheduled read beats, indexed by edge count since reset.
  logic [63:0] m_mem [4096];
  int          m_e, m_rd_end, m_ref_end, m_wr_left;
  logic [AB-1:0] m_wr_addr;
  logic        m_pend, m_busy, m_rdy, m_err;
  logic [63:0] m_dout;
  int          q_cyc[$];
  logic [63:0] q_dat[$];

  task automatic mwrite(input logic [AB-1:0] a);
    for (int b = 0; b < 8; b++)
      if (DDRAM_BE[b]) m_mem[a][8*b +: 8] = DDRAM_DIN[8*b +: 8];
  endtask

  always @(posedge clk) begin : model
    logic idle_prev, idle_after;
    int bc;
    logic [AB-1:0] a;
    if (reset) begin
      m_e = 0; m_rd_end = -1; m_ref_end = -1; m_wr_left = 0;
      m_pend = 1'b0; m_err = 1'b0; m_rdy = 1'b0; m_dout = 64'd0; m_busy = 1'b0;
      q_cyc.delete(); q_dat.delete();
    end else begin
      m_e++;
      idle_prev = (m_e - 1 > m_rd_end) && (m_wr_left == 0) && (m_e - 1 > m_ref_end);
      if (idle_prev && m_pend) begin
        m_ref_end = m_e + RL - 1;
        m_pend = 1'b0;
      end else if (idle_prev && (DDRAM_RD || DDRAM_WE)) begin
        bc = (DDRAM_BURSTCNT == 8'd0) ? 1 : int'(DDRAM_BURSTCNT);
        if (DDRAM_BURSTCNT == 8'd0 || (DDRAM_RD && DDRAM_WE)) m_err = 1'b1;
        a = DDRAM_ADDR[AB-1:0];
        if (DDRAM_WE) begin
          mwrite(a);
          m_wr_addr = a + 1'b1;
          m_wr_left = bc - 1;
        end else begin
          for (int i = 0; i < bc; i++) begin
            q_cyc.push_back(m_e + LAT + i);
            q_dat.push_back(m_mem[(int'(a) + i) % 4096]);
          end
          m_rd_end = m_e + LAT + bc - 1;
        end
      end else if (m_wr_left > 0 && DDRAM_WE) begin
        mwrite(m_wr_addr);
        m_wr_addr = m_wr_addr + 1'b1;
        m_wr_left--;
      end
      if (m_e % RP == 0) m_pend = 1'b1;
      m_rdy = 1'b0;
      if (q_cyc.size() > 0 && q_cyc[0] == m_e) begin
        m_rdy = 1'b1;
        m_dout = q_dat.pop_front();
        void'(q_cyc.pop_front());
      end
      idle_after = (m_e > m_rd_end) && (m_wr_left == 0) && (m_e > m_ref_end);
      m_busy = (m_e <= m_rd_end) || (m_e <= m_ref_end) || (idle_after && m_pend);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", 64'(DDRAM_BUSY), 64'(m_busy));
      chk("dout_ready", 64'(DDRAM_DOUT_READY), 64'(m_rdy));
      chk("dout", DDRAM_DOUT, m_dout);
      chk("err", 64'(err), 64'(m_err));
    end
  end

  logic [63:0] got_d[$];
  int          got_c[$];
  always @(posedge clk) begin
    #2;
    if (DDRAM_DOUT_READY === 1'b1) begin
      got_d.push_back(DDRAM_DOUT);
      got_c.push_back(cyc);
    end
  end

  logic [63:0] wd  [256];
  logic [7:0]  wbe [256];
  int          wst [256];

  task automatic present_wait();
    int t = 0;
    while (DDRAM_BUSY && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: busy still %b, required 0 within 300 cycles", DDRAM_BUSY);
    end
    acc_cyc = cyc + 1;
    @(negedge clk);
  endtask

  task automatic wait_beats(input int n);
    int t = 0;
    while (got_d.size() < n && t < 600) begin @(negedge clk); t++; end
    if (t >= 600) begin
      n_checks++; n_fail++;
      $display("FAIL beat_timeout: got %0d beats, required %0d", got_d.size(), n);
    end
  endtask

  task automatic wr_burst(input logic [28:0] addr, input logic [7:0] bcf, input int n);
    DDRAM_ADDR = addr; DDRAM_BURSTCNT = bcf; DDRAM_DIN = wd[0]; DDRAM_BE = wbe[0]; DDRAM_WE = 1'b1;
    present_wait();
    for (int i = 1; i < n; i++) begin
      for (int s = 0; s < wst[i]; s++) begin
        DDRAM_WE = 1'b0; DDRAM_DIN = {$urandom, $urandom}; DDRAM_BE = 8'hFF;
        @(negedge clk);
      end
      DDRAM_ADDR = 29'($urandom);
      DDRAM_WE = 1'b1; DDRAM_DIN = wd[i]; DDRAM_BE = wbe[i];
      @(negedge clk);
    end
    DDRAM_WE = 1'b0;
  endtask

  task automatic rd_burst(input logic [28:0] addr, input logic [7:0] bcf);
    got_d.delete(); got_c.delete();
    DDRAM_ADDR = addr; DDRAM_BURSTCNT = bcf; DDRAM_RD = 1'b1;
    present_wait();
    DDRAM_RD = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] wrapv [4];
    reset = 1'b1; DDRAM_RD = 1'b0; DDRAM_WE = 1'b0; DDRAM_ADDR = '0;
    DDRAM_BURSTCNT = 8'd1; DDRAM_DIN = '0; DDRAM_BE = 8'hFF;
    for (int i = 0; i < 256; i++) begin wst[i] = 0; wbe[i] = 8'hFF; end
    repeat (3) @(negedge clk);
    chk("reset_dout_ready", 64'(DDRAM_DOUT_READY), 64'd0);
    chk("reset_dout", DDRAM_DOUT, 64'd0);
    chk("reset_err", 64'(err), 64'd0);
    chk_on = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    chk("busy_after_reset", 64'(DDRAM_BUSY), 64'd0);

    // Fill the whole store so every later read has a defined value.
    for (int blk = 0; blk < 32; blk++) begin
      for (int i = 0; i < 128; i++) wd[i] = {$urandom, $urandom};
      wr_burst(29'(blk * 128), 8'd128, 128);
    end

    // Single write then immediate read; upper address bits ignored.
    wd[0] = 64'h0123456789ABCDEF; wbe[0] = 8'hFF;
    wr_burst(29'h3000005, 8'd1, 1);
    rd_burst(29'd5, 8'd1);
    wait_beats(1);
    repeat (4) @(negedge clk);
    chk("single_latency", 64'(got_c[0] - acc_cyc), 64'd4);
    chk("single_data", got_d[0], 64'h0123456789ABCDEF);
    chk("single_pulses", 64'(got_d.size()), 64'd1);

    // Byte enables.
    wd[0] = '1; wr_burst(29'd7, 8'd1, 1);
    wd[0] = '0; wbe[0] = 8'h0F; wr_burst(29'd7, 8'd1, 1);
    wbe[0] = 8'hFF;
    rd_burst(29'd7, 8'd1);
    wait_beats(1);
    chk("byte_enable", got_d[0], 64'hFFFFFFFF00000000);

    // Wrapping burst with a mid-burst WE stall.
    wrapv[0] = 64'hA0A0A0A0A0A00FFE; wrapv[1] = 64'hA1A1A1A1A1A10FFF;
    wrapv[2] = 64'hA2A2A2A2A2A20000; wrapv[3] = 64'hA3A3A3A3A3A30001;
    for (int i = 0; i < 4; i++) wd[i] = wrapv[i];
    wst[2] = 1;
    wr_burst(29'hFFE, 8'd4, 4);
    wst[2] = 0;
    rd_burst(29'hFFE, 8'd4);
    wait_beats(4);
    chk("wrap_beat0", got_d[0], 64'hA0A0A0A0A0A00FFE);
    chk("wrap_beat1", got_d[1], 64'hA1A1A1A1A1A10FFF);
    chk("wrap_beat2", got_d[2], 64'hA2A2A2A2A2A20000);
    chk("wrap_beat3", got_d[3], 64'hA3A3A3A3A3A30001);
    chk("wrap_consecutive", 64'(got_c[3] - got_c[0]), 64'd3);

    // Refresh falling inside read latency: read completes on time, then 1+3 busy cycles.
    for (int t = 0; t < 100 && !(((m_e % RP) == 13) && !DDRAM_BUSY); t++) @(negedge clk);
    got_d.delete(); got_c.delete();
    DDRAM_ADDR = 29'd5; DDRAM_BURSTCNT = 8'd1; DDRAM_RD = 1'b1;
    present_wait();
    begin
      int acc1;
      acc1 = acc_cyc;
      DDRAM_ADDR = 29'd7;
      present_wait();
      DDRAM_RD = 1'b0;
      wait_beats(2);
      chk("refresh_read_latency", 64'(got_c[0] - acc1), 64'd4);
      chk("refresh_read_data", got_d[0], 64'h0123456789ABCDEF);
      chk("refresh_next_accept", 64'(acc_cyc - got_c[0]), 64'd6);
      chk("refresh_second_data", got_d[1], 64'hFFFFFFFF00000000);
    end

    // BURSTCNT=0 read: one beat, err set.
    rd_burst(29'd5, 8'd0);
    wait_beats(1);
    repeat (6) @(negedge clk);
    chk("bc0_beats", 64'(got_d.size()), 64'd1);
    chk("bc0_data", got_d[0], 64'h0123456789ABCDEF);
    chk("bc0_err", 64'(err), 64'd1);

    // Fresh run: simultaneous RD and WE.
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    chk("reset_clears_err", 64'(err), 64'd0);
    got_d.delete(); got_c.delete();
    DDRAM_ADDR = 29'd9; DDRAM_BURSTCNT = 8'd1; DDRAM_DIN = 64'hDEADBEEFCAFEF00D;
    DDRAM_BE = 8'hFF; DDRAM_WE = 1'b1; DDRAM_RD = 1'b1;
    present_wait();
    DDRAM_WE = 1'b0; DDRAM_RD = 1'b0;
    repeat (10) @(negedge clk);
    chk("rdwe_no_beat", 64'(got_d.size()), 64'd0);
    chk("rdwe_err", 64'(err), 64'd1);
    rd_burst(29'd9, 8'd1);
    wait_beats(1);
    chk("rdwe_write_done", got_d[0], 64'hDEADBEEFCAFEF00D);
    chk("rdwe_err_sticky", 64'(err), 64'd1);

    // Reset in the middle of an 8-beat read.
    for (int i = 0; i < 8; i++) wd[i] = 64'h5500 + 64'(i);
    wr_burst(29'h100, 8'd8, 8);
    rd_burst(29'h100, 8'd8);
    wait_beats(2);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    chk("midreset_ready", 64'(DDRAM_DOUT_READY), 64'd0);
    chk("midreset_busy", 64'(DDRAM_BUSY), 64'd0);
    repeat (10) @(negedge clk);
    chk("midreset_beats", 64'(got_d.size()), 64'd2);
    chk("midreset_beat1", got_d[1], 64'h5501);
    rd_burst(29'h100, 8'd8);
    wait_beats(8);
    for (int i = 0; i < 8; i++) chk("after_reset_read", got_d[i], 64'h5500 + 64'(i));

    // Randomised traffic checked cycle by cycle against the model.
    for (int t = 0; t < 300; t++) begin
      int n;
      logic [7:0] bcf;
      logic [28:0] a;
      bcf = 8'($urandom_range(1, 6));
      if ($urandom_range(0, 49) == 0) bcf = 8'd0;
      n = (bcf == 8'd0) ? 1 : int'(bcf);
      a = 29'($urandom);
      if ($urandom_range(0, 3) == 0) a[11:0] = 12'hFFC + 12'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < n; i++) begin
          wd[i]  = {$urandom, $urandom};
          wbe[i] = 8'($urandom);
          wst[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
        end
        wr_burst(a, bcf, n);
      end else begin
        rd_burst(a, bcf);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
